mem_burst_master: RTL

- Initiator side of the cache-to-main-memory interface: drives the single-port RAM's addr/datain/RE/WE and collects dataout.
- Converts one line-level request from the cache controller (optional write-back of a victim line, then optional refill of a new line) into word-by-word RAM accesses.
- Returns the refilled line as one wide word.
- Sits between the cache controller FSM and the RAM; it is the only agent that drives the RAM.

---
 rtl/mem_burst_master_pkg.sv | 25 ++
 rtl/mem_burst_master_if.sv | 42 ++++
 rtl/mem_burst_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_burst_master_pkg.sv
// Shared types and defaults for the cache-to-memory burst master.
// Holds the FSM state encoding and the line geometry helpers.
package mem_burst_master_pkg;

  localparam int DEF_ADDLENGTH      = 16;
  localparam int DEF_DATALENGTH     = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int offw(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int line_width(input int data_length, input int words_per_line);
    return data_length * words_per_line;
  endfunction

endpackage

// File: rtl/mem_burst_master_if.sv
// Bundle of the line-request handshake and the single-port RAM bus.
// The master modport is the burst master's view; slave is the environment's.
interface mem_burst_master_if
  import mem_burst_master_pkg::*;
#(
  parameter int ADDLENGTH      = DEF_ADDLENGTH,
  parameter int DATALENGTH     = DEF_DATALENGTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);

  localparam int LINEW = line_width(DATALENGTH, WORDS_PER_LINE);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wb;
  logic                  req_fill;
  logic [ADDLENGTH-1:0]  req_wb_addr;
  logic [ADDLENGTH-1:0]  req_fill_addr;
  logic [LINEW-1:0]      req_wb_line;
  logic                  rsp_valid;
  logic [LINEW-1:0]      rsp_line;
  logic [ADDLENGTH-1:0]  mem_addr;
  logic [DATALENGTH-1:0] mem_datain;
  logic                  mem_RE;
  logic                  mem_WE;
  logic [DATALENGTH-1:0] mem_dataout;

  modport master (
    input  req_valid, req_wb, req_fill, req_wb_addr, req_fill_addr, req_wb_line,
    input  mem_dataout,
    output req_ready, rsp_valid, rsp_line,
    output mem_addr, mem_datain, mem_RE, mem_WE
  );

  modport slave (
    output req_valid, req_wb, req_fill, req_wb_addr, req_fill_addr, req_wb_line,
    output mem_dataout,
    input  req_ready, rsp_valid, rsp_line,
    input  mem_addr, mem_datain, mem_RE, mem_WE
  );

endinterface

// File: rtl/mem_burst_master.sv
// Turns one line request (optional victim write-back, then optional refill)
// into word-by-word RAM accesses and returns the refilled line as one wide word.
module mem_burst_master
  import mem_burst_master_pkg::*;
#(
  parameter int ADDLENGTH      = DEF_ADDLENGTH,
  parameter int DATALENGTH     = DEF_DATALENGTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  mem_burst_master_if.master bus
);

  localparam int OFFW = offw(WORDS_PER_LINE);

  localparam logic [OFFW-1:0]      LAST_OFF  = OFFW'(WORDS_PER_LINE - 1);
  localparam logic [ADDLENGTH-1:0] BASE_MASK = ~ADDLENGTH'(WORDS_PER_LINE - 1);

  typedef logic [WORDS_PER_LINE-1:0][DATALENGTH-1:0] line_t;

  state_e                state_q, state_d;
  logic [OFFW-1:0]       cnt_q, cnt_d;
  logic [ADDLENGTH-1:0]  wb_base_q, wb_base_d;
  logic [ADDLENGTH-1:0]  fill_base_q, fill_base_d;
  line_t                 wb_line_q, wb_line_d;
  line_t                 line_buf_q, line_buf_d;
  line_t                 rsp_line_q, rsp_line_d;
  logic                  fill_q, fill_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [OFFW-1:0]       cap_idx_q, cap_idx_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDLENGTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATALENGTH-1:0] mem_datain_q, mem_datain_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    wb_line_d   = wb_line_q;
    fill_d      = fill_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wb_base_d   = bus.req_wb_addr & BASE_MASK;
          fill_base_d = bus.req_fill_addr & BASE_MASK;
          wb_line_d   = bus.req_wb_line;
          fill_d      = bus.req_fill;
          cnt_d       = '0;
          if (bus.req_wb)        state_d = WB;
          else if (bus.req_fill) state_d = FILL;
          else                   state_d = DONE;
        end
      end
      WB: begin
        if (cnt_q == LAST_OFF) begin
          cnt_d   = '0;
          state_d = fill_q ? FILL : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL: begin
        if (cnt_q == LAST_OFF) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM data lags RE by one cycle, so the capture slot trails the address slot.
  always_comb begin
    cap_vld_d  = mem_re_q;
    cap_idx_d  = cnt_q;
    line_buf_d = line_buf_q;
    if (cap_vld_q) begin
      line_buf_d[cap_idx_q] = bus.mem_dataout;
    end
  end

  // Outputs are registered from the next-state view so the first strobe
  // appears in the cycle right after acceptance.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    rsp_valid_d  = (state_d == DONE);
    rsp_line_d   = rsp_line_q;
    mem_we_d     = (state_d == WB);
    mem_re_d     = (state_d == FILL);
    mem_addr_d   = '0;
    mem_datain_d = '0;
    if (state_d == DONE && fill_d) begin
      rsp_line_d = line_buf_d;
    end
    if (state_d == WB) begin
      mem_addr_d   = wb_base_d | ADDLENGTH'(cnt_d);
      mem_datain_d = wb_line_d[cnt_d];
    end else if (state_d == FILL) begin
      mem_addr_d = fill_base_d | ADDLENGTH'(cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_base_q    <= '0;
      fill_base_q  <= '0;
      wb_line_q    <= '0;
      line_buf_q   <= '0;
      rsp_line_q   <= '0;
      fill_q       <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_idx_q    <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_base_q    <= wb_base_d;
      fill_base_q  <= fill_base_d;
      wb_line_q    <= wb_line_d;
      line_buf_q   <= line_buf_d;
      rsp_line_q   <= rsp_line_d;
      fill_q       <= fill_d;
      cap_vld_q    <= cap_vld_d;
      cap_idx_q    <= cap_idx_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_line   = rsp_line_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_datain = mem_datain_q;
  assign bus.mem_RE     = mem_re_q;
  assign bus.mem_WE     = mem_we_q;

endmodule
